pc_fetch_unit: RTL and testbench

Program-counter register and next-PC sequencer for the RV32I core's fetch stage. Drives curr_pc into the PC+4 adder and consumes its pc_plus_4 result. Selects among sequential, branch, JAL and JALR targets and issues fetch requests to instruction memory with a req/ready handshake. Detects misaligned control-flow targets, redirects to a trap vector and latches the faulting address.

---
 rtl/core_pkg.sv | 21 ++
 rtl/pc_fetch_unit_if.sv | 9 +
 rtl/pc_next_sel.sv | 35 +++
 rtl/pc_fetch_unit.sv | 72 +++++++
 tb/tb_pc_fetch_unit.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants, FSM/select encodings and alignment helper for the fetch stage
package core_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

  localparam logic [0:0] ST_BOOT  = 1'b0;
  localparam logic [0:0] ST_FETCH = 1'b1;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'd0,
    SEL_BR   = 2'd1,
    SEL_JAL  = 2'd2,
    SEL_JALR = 2'd3
  } pc_sel_e;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction-memory fetch request/ready handshake
interface pc_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;

  modport master (output req, output addr, input ready);
  modport slave  (input req, input addr, output ready);
endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC priority mux (jalr > jal > branch > pc+4) with alignment check
module pc_next_sel
  import core_pkg::*;
(
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jal,
  input  logic [31:0] jal_target,
  input  logic        jalr,
  input  logic [31:0] jalr_target,
  input  logic [31:0] pc_plus_4,
  output logic [31:0] next_pc,
  output pc_sel_e     sel,
  output logic        misaligned
);

  always_comb begin
    sel     = SEL_SEQ;
    next_pc = pc_plus_4;
    if (jalr) begin
      sel     = SEL_JALR;
      next_pc = {jalr_target[31:1], 1'b0};
    end else if (jal) begin
      sel     = SEL_JAL;
      next_pc = jal_target;
    end else if (branch_taken) begin
      sel     = SEL_BR;
      next_pc = branch_target;
    end
  end

  // Raw check on whichever address was chosen; the caller decides which paths may trap.
  assign misaligned = is_misaligned(next_pc);

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, boot/fetch FSM, imem request and misaligned-target trap
module pc_fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  input  logic                   jal,
  input  logic [31:0]            jal_target,
  input  logic                   jalr,
  input  logic [31:0]            jalr_target,
  input  logic [31:0]            pc_plus_4,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            curr_pc,
  output logic                   misalign_trap,
  output logic [31:0]            bad_addr
);

  logic [0:0]  state;
  logic        adv;
  logic        take_trap;
  logic [31:0] next_pc;
  pc_sel_e     sel;
  logic        misaligned;

  pc_next_sel u_next_sel (
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jal           (jal),
    .jal_target    (jal_target),
    .jalr          (jalr),
    .jalr_target   (jalr_target),
    .pc_plus_4     (pc_plus_4),
    .next_pc       (next_pc),
    .sel           (sel),
    .misaligned    (misaligned)
  );

  assign imem.req  = (state == ST_FETCH);
  assign imem.addr = curr_pc;

  assign adv = (state == ST_FETCH) & imem.ready & ~stall;
  // Sequential pc+4 (including the wrap to zero) is never a trap source.
  assign take_trap = adv & misaligned & (sel != SEL_SEQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_BOOT;
      curr_pc       <= RESET_PC;
      misalign_trap <= 1'b0;
      bad_addr      <= 32'h0;
    end else begin
      misalign_trap <= 1'b0;
      if (state == ST_BOOT) begin
        state <= ST_FETCH;
      end
      if (take_trap) begin
        curr_pc       <= TRAP_VEC;
        bad_addr      <= next_pc;
        misalign_trap <= 1'b1;
      end else if (adv) begin
        curr_pc <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed vector bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jal;
  logic [31:0] jal_target;
  logic        jalr;
  logic [31:0] jalr_target;
  logic [31:0] pc_plus_4;
  logic [31:0] curr_pc;
  logic        misalign_trap;
  logic [31:0] bad_addr;

  pc_fetch_unit_if imem ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TRAP_VEC(32'h0000_0100)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jal           (jal),
    .jal_target    (jal_target),
    .jalr          (jalr),
    .jalr_target   (jalr_target),
    .pc_plus_4     (pc_plus_4),
    .imem          (imem),
    .curr_pc       (curr_pc),
    .misalign_trap (misalign_trap),
    .bad_addr      (bad_addr)
  );

  assign pc_plus_4 = curr_pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        ready;
    logic        br;
    logic [31:0] br_t;
    logic        jal;
    logic [31:0] jal_t;
    logic        jalr;
    logic [31:0] jalr_t;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_trap;
    logic [31:0] e_bad;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic r, input logic s, input logic rd,
    input logic b, input logic [31:0] bt,
    input logic j, input logic [31:0] jt,
    input logic jr, input logic [31:0] jrt,
    input logic [31:0] pc, input logic rq, input logic tr, input logic [31:0] bad);
    vec_t v;
    v.rst = r; v.stall = s; v.ready = rd;
    v.br = b; v.br_t = bt; v.jal = j; v.jal_t = jt; v.jalr = jr; v.jalr_t = jrt;
    v.e_pc = pc; v.e_req = rq; v.e_trap = tr; v.e_bad = bad;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; stall = v.stall; imem.ready = v.ready;
    branch_taken = v.br; branch_target = v.br_t;
    jal = v.jal; jal_target = v.jal_t;
    jalr = v.jalr; jalr_target = v.jalr_t;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; imem.ready = 1'b1;
    branch_taken = 1'b0; branch_target = '0;
    jal = 1'b0; jal_target = '0; jalr = 1'b0; jalr_target = '0;

    //           rst stl rdy br  br_t          jal j_t           jr  jr_t          pc            req trp bad
    vecs.push_back(mk(1, 0, 1, 0, 0,            0, 0,            0, 0,            32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0,            0, 0,            0, 0,            32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0,            0, 0,            0, 0,            32'h4,        1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0,            0, 0,            0, 0,            32'h8,        1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0,            0, 0,            32'h8,        1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0,            1, 32'h40,       0, 0,            32'h8,        1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0,            0, 0,            32'h8,        1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h1002,     1, 32'h40,       0, 0,            32'h8,        1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 0,            0, 0,            0, 0,            32'h8,        1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0,            0, 0,            0, 0,            32'hC,        1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0,            1, 32'h20,       0, 0,            32'h20,       1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h90,       1, 32'h80,       1, 32'h41,       32'h40,       1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h90,       1, 32'h80,       0, 0,            32'h80,       1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h1002,     0, 0,            0, 0,            32'h100,      1, 1, 32'h1002));
    vecs.push_back(mk(0, 0, 1, 0, 0,            0, 0,            0, 0,            32'h104,      1, 0, 32'h1002));
    vecs.push_back(mk(0, 0, 1, 0, 0,            0, 0,            1, 32'h2003,     32'h100,      1, 1, 32'h2002));
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0,            0, 0,            32'h100,      1, 0, 32'h2002));
    vecs.push_back(mk(0, 0, 1, 0, 0,            1, 32'hFFFF_FFFC, 0, 0,           32'hFFFF_FFFC, 1, 0, 32'h2002));
    vecs.push_back(mk(0, 0, 1, 0, 0,            0, 0,            0, 0,            32'h0,        1, 0, 32'h2002));
    vecs.push_back(mk(0, 0, 1, 0, 0,            1, 32'h44,       0, 0,            32'h44,       1, 0, 32'h2002));
    vecs.push_back(mk(1, 0, 0, 0, 0,            0, 0,            0, 0,            32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0,            0, 0,            32'h0,        1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h1,        1, 32'h6,        0, 0,            32'h100,      1, 1, 32'h6));
    vecs.push_back(mk(0, 0, 1, 1, 32'h1,        0, 0,            1, 32'h9,        32'h8,        1, 0, 32'h6));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d curr_pc", i), curr_pc, vecs[i].e_pc);
      chk($sformatf("v%0d imem_addr", i), imem.addr, vecs[i].e_pc);
      chk($sformatf("v%0d imem_req", i), {31'h0, imem.req}, {31'h0, vecs[i].e_req});
      chk($sformatf("v%0d misalign_trap", i), {31'h0, misalign_trap}, {31'h0, vecs[i].e_trap});
      chk($sformatf("v%0d bad_addr", i), bad_addr, vecs[i].e_bad);
    end

    // Sequential run with no bubbles: one PC per cycle from 0x8.
    rst = 1'b0; stall = 1'b0; imem.ready = 1'b1;
    branch_taken = 1'b0; jal = 1'b0; jalr = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("seq%0d curr_pc", k), curr_pc, 32'h8 + 32'(4 * k));
      chk($sformatf("seq%0d misalign_trap", k), {31'h0, misalign_trap}, 32'h0);
    end

    // Trap pulse lasts exactly one cycle even when the next cycle stalls.
    jal = 1'b1; jal_target = 32'h3002;
    @(posedge clk);
    #1;
    jal = 1'b0; stall = 1'b1;
    chk("pulse_hi", {31'h0, misalign_trap}, 32'h1);
    chk("pulse_pc", curr_pc, 32'h100);
    @(posedge clk);
    #1;
    chk("pulse_lo", {31'h0, misalign_trap}, 32'h0);
    chk("pulse_hold_pc", curr_pc, 32'h100);
    chk("pulse_bad", bad_addr, 32'h3002);
    stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
